// File: rtl/hd44780_pkg.sv
// Shared opcodes, transfer request payload and timing helpers for the HD44780 controller.
package hd44780_pkg;

  localparam int unsigned WAIT_W = 24;

  localparam logic [7:0] OP_FS_BASE   = 8'h20;
  localparam logic [7:0] OP_DC        = 8'h0C;
  localparam logic [7:0] OP_EM        = 8'h06;
  localparam logic [7:0] OP_CLR       = 8'h01;
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;

  typedef struct packed {
    logic              is_data;
    logic              nibble_only;
    logic [7:0]        data;
    logic [WAIT_W-1:0] wait_cyc;
  } xfer_t;

  // Ceiling of clk_hz * ns / 1e9, never below one cycle.
  function automatic int unsigned cycles(longint unsigned clk_hz, longint unsigned ns);
    longint unsigned c;
    c = (clk_hz * ns + 64'd999_999_999) / 64'd1_000_000_000;
    return (c == 64'd0) ? 32'd1 : 32'(c);
  endfunction

  function automatic logic [7:0] row_base(logic [1:0] r, int unsigned cols);
    case (r)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'(cols);
      default: return 8'(32'h40 + cols);
    endcase
  endfunction

endpackage

// File: rtl/hd44780_bus.sv
// LCD bus transfer engine: SETUP/PULSE/HOLD per nibble or byte, then a post-transfer wait.
module hd44780_bus
  import hd44780_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_is_data,
  input  logic [7:0]           i_byte,
  input  logic                 i_nibble_only,
  input  logic [WAIT_W-1:0]    i_wait_cyc,
  output logic                 o_ready,
  output logic                 o_e,
  output logic                 o_rs,
  output logic [BUS_WIDTH-1:0] o_db
);

  localparam logic [2:0] B_IDLE  = 3'd0;
  localparam logic [2:0] B_SETUP = 3'd1;
  localparam logic [2:0] B_PULSE = 3'd2;
  localparam logic [2:0] B_HOLD  = 3'd3;
  localparam logic [2:0] B_WAIT  = 3'd4;

  logic [2:0]           r_state, w_state_nx;
  logic [7:0]           r_byte, w_byte_nx;
  logic                 r_lo_pending, w_lo_pending_nx;
  logic [WAIT_W-1:0]    r_wait, w_wait_nx;
  logic [WAIT_W-1:0]    r_cnt, w_cnt_nx;
  logic                 r_ready, w_ready_nx;
  logic                 r_e, w_e_nx;
  logic                 r_rs, w_rs_nx;
  logic [BUS_WIDTH-1:0] r_db, w_db_nx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= B_IDLE;
      r_byte       <= 8'h00;
      r_lo_pending <= 1'b0;
      r_wait       <= '0;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_e          <= 1'b0;
      r_rs         <= 1'b0;
      r_db         <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_byte       <= w_byte_nx;
      r_lo_pending <= w_lo_pending_nx;
      r_wait       <= w_wait_nx;
      r_cnt        <= w_cnt_nx;
      r_ready      <= w_ready_nx;
      r_e          <= w_e_nx;
      r_rs         <= w_rs_nx;
      r_db         <= w_db_nx;
    end
  end

  // rs/db only move on entry to SETUP; in 4-bit mode a full byte goes high nibble first.
  always_comb begin
    w_state_nx      = r_state;
    w_byte_nx       = r_byte;
    w_lo_pending_nx = r_lo_pending;
    w_wait_nx       = r_wait;
    w_cnt_nx        = r_cnt;
    w_e_nx          = 1'b0;
    w_rs_nx         = r_rs;
    w_db_nx         = r_db;
    case (r_state)
      B_IDLE: begin
        if (i_start) begin
          w_state_nx      = B_SETUP;
          w_byte_nx       = i_byte;
          w_wait_nx       = i_wait_cyc;
          w_rs_nx         = i_is_data;
          w_lo_pending_nx = (BUS_WIDTH != 8) && !i_nibble_only;
          if (BUS_WIDTH == 8)     w_db_nx = BUS_WIDTH'(i_byte);
          else if (i_nibble_only) w_db_nx = BUS_WIDTH'(i_byte[3:0]);
          else                    w_db_nx = BUS_WIDTH'(i_byte[7:4]);
        end
      end
      B_SETUP: begin
        w_state_nx = B_PULSE;
        w_e_nx     = 1'b1;
      end
      B_PULSE: w_state_nx = B_HOLD;
      B_HOLD: begin
        if (r_lo_pending) begin
          w_state_nx      = B_SETUP;
          w_lo_pending_nx = 1'b0;
          w_db_nx         = BUS_WIDTH'(r_byte[3:0]);
        end else begin
          w_state_nx = B_WAIT;
          w_cnt_nx   = r_wait;
        end
      end
      B_WAIT: begin
        if (r_cnt <= WAIT_W'(1)) w_state_nx = B_IDLE;
        else                     w_cnt_nx   = r_cnt - WAIT_W'(1);
      end
      default: w_state_nx = B_IDLE;
    endcase
    w_ready_nx = (w_state_nx == B_IDLE);
  end

  assign o_ready = r_ready;
  assign o_e     = r_e;
  assign o_rs    = r_rs;
  assign o_db    = r_db;

endmodule

// File: rtl/hd44780_ctrl.sv
// HD44780 controller: power-on init, host character buffer and queued full-screen refresh.
module hd44780_ctrl
  import hd44780_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 250_000,
  parameter int unsigned BUS_WIDTH = 4,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned COLS      = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr_en,
  input  logic [$clog2(ROWS*COLS)-1:0] i_wr_addr,
  input  logic [7:0]                   i_wr_data,
  input  logic                         i_refresh,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_e,
  output logic                         o_rs,
  output logic [BUS_WIDTH-1:0]         o_db
);

  localparam int unsigned DEPTH   = ROWS * COLS;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned T_POR   = cycles(64'(CLK_HZ), 64'd100_000_000);
  localparam int unsigned T_4MS   = cycles(64'(CLK_HZ), 64'd4_100_000);
  localparam int unsigned T_100US = cycles(64'(CLK_HZ), 64'd100_000);
  localparam int unsigned T_EXEC  = cycles(64'(CLK_HZ), 64'd40_000);
  localparam int unsigned T_CLR   = cycles(64'(CLK_HZ), 64'd1_640_000);
  localparam int unsigned N_INIT  = (BUS_WIDTH == 8) ? 7 : 8;
  localparam logic [7:0]  FS      = OP_FS_BASE | ((BUS_WIDTH == 8) ? 8'h10 : 8'h00)
                                               | ((ROWS > 1) ? 8'h08 : 8'h00);

  localparam logic [2:0] S_POR        = 3'd0;
  localparam logic [2:0] S_INIT       = 3'd1;
  localparam logic [2:0] S_IDLE       = 3'd2;
  localparam logic [2:0] S_SET_ADDR   = 3'd3;
  localparam logic [2:0] S_WRITE_CHAR = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]        r_state, w_state_nx;
  logic [WAIT_W-1:0] r_cnt, w_cnt_nx;
  logic [3:0]        r_step, w_step_nx;
  logic [1:0]        r_row, w_row_nx;
  logic [4:0]        r_col, w_col_nx;
  logic [AW-1:0]     r_addr, w_addr_nx;
  logic              r_pending, w_pending_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;
  logic [7:0]        r_buf [DEPTH];
  logic              w_start;
  logic              w_ready;
  xfer_t             w_xfer;

  // 8-bit mode skips the lone 0x2 nibble that switches the panel to 4-bit.
  function automatic xfer_t init_xfer(logic [3:0] step);
    xfer_t      x;
    logic [3:0] s;
    s             = (BUS_WIDTH == 8 && step >= 4'd3) ? step + 4'd1 : step;
    x             = '0;
    x.nibble_only = 1'b1;
    x.data        = (BUS_WIDTH == 8) ? 8'h30 : 8'h03;
    x.wait_cyc    = WAIT_W'(T_100US);
    case (s)
      4'd0:    x.wait_cyc = WAIT_W'(T_4MS);
      4'd1,
      4'd2:    x.wait_cyc = WAIT_W'(T_100US);
      4'd3:    begin x.data = 8'h02; x.wait_cyc = WAIT_W'(T_EXEC); end
      4'd4:    begin x.nibble_only = 1'b0; x.data = FS;    x.wait_cyc = WAIT_W'(T_EXEC); end
      4'd5:    begin x.nibble_only = 1'b0; x.data = OP_DC; x.wait_cyc = WAIT_W'(T_EXEC); end
      4'd6:    begin x.nibble_only = 1'b0; x.data = OP_EM; x.wait_cyc = WAIT_W'(T_EXEC); end
      default: begin x.nibble_only = 1'b0; x.data = OP_CLR; x.wait_cyc = WAIT_W'(T_CLR); end
    endcase
    return x;
  endfunction

  function automatic xfer_t addr_xfer(logic [1:0] row);
    return '{is_data: 1'b0, nibble_only: 1'b0,
             data: OP_SET_DDRAM | row_base(row, COLS), wait_cyc: WAIT_W'(T_EXEC)};
  endfunction

  function automatic xfer_t data_xfer(logic [7:0] ch);
    return '{is_data: 1'b1, nibble_only: 1'b0, data: ch, wait_cyc: WAIT_W'(T_EXEC)};
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_buf[i] <= 8'h20;
    end else if (i_wr_en && ({1'b0, i_wr_addr} < (AW+1)'(DEPTH))) begin
      r_buf[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_POR;
      r_cnt     <= '0;
      r_step    <= 4'd0;
      r_row     <= 2'd0;
      r_col     <= 5'd0;
      r_addr    <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_step    <= w_step_nx;
      r_row     <= w_row_nx;
      r_col     <= w_col_nx;
      r_addr    <= w_addr_nx;
      r_pending <= w_pending_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
    end
  end

  // Buffer is read when a character transfer starts, so a same-cycle write is seen next refresh.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_step_nx    = r_step;
    w_row_nx     = r_row;
    w_col_nx     = r_col;
    w_addr_nx    = r_addr;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_pending_nx = r_pending | (i_refresh & r_busy);
    w_start      = 1'b0;
    w_xfer       = '0;
    case (r_state)
      S_POR: begin
        if (r_cnt == WAIT_W'(T_POR - 1)) begin
          w_start    = 1'b1;
          w_xfer     = init_xfer(4'd0);
          w_step_nx  = 4'd0;
          w_state_nx = S_INIT;
        end else begin
          w_cnt_nx = r_cnt + WAIT_W'(1);
        end
      end
      S_INIT: begin
        if (w_ready) begin
          if (r_step == 4'(N_INIT - 1)) begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
          end else begin
            w_start   = 1'b1;
            w_xfer    = init_xfer(r_step + 4'd1);
            w_step_nx = r_step + 4'd1;
          end
        end
      end
      S_IDLE, S_DONE: begin
        w_state_nx = S_IDLE;
        if (i_refresh || r_pending) begin
          w_start      = 1'b1;
          w_xfer       = addr_xfer(2'd0);
          w_row_nx     = 2'd0;
          w_addr_nx    = '0;
          w_pending_nx = 1'b0;
          w_busy_nx    = 1'b1;
          w_state_nx   = S_SET_ADDR;
        end
      end
      S_SET_ADDR: begin
        if (w_ready) begin
          w_start    = 1'b1;
          w_xfer     = data_xfer(r_buf[r_addr]);
          w_addr_nx  = r_addr + AW'(1);
          w_col_nx   = 5'd0;
          w_state_nx = S_WRITE_CHAR;
        end
      end
      S_WRITE_CHAR: begin
        if (w_ready) begin
          if (r_col != 5'(COLS - 1)) begin
            w_start   = 1'b1;
            w_xfer    = data_xfer(r_buf[r_addr]);
            w_addr_nx = r_addr + AW'(1);
            w_col_nx  = r_col + 5'd1;
          end else if (r_row != 2'(ROWS - 1)) begin
            w_start    = 1'b1;
            w_xfer     = addr_xfer(r_row + 2'd1);
            w_row_nx   = r_row + 2'd1;
            w_state_nx = S_SET_ADDR;
          end else begin
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_state_nx = S_DONE;
          end
        end
      end
      default: w_state_nx = S_POR;
    endcase
  end

  hd44780_bus #(.BUS_WIDTH(BUS_WIDTH)) u_bus (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (w_start),
    .i_is_data     (w_xfer.is_data),
    .i_byte        (w_xfer.data),
    .i_nibble_only (w_xfer.nibble_only),
    .i_wait_cyc    (w_xfer.wait_cyc),
    .o_ready       (w_ready),
    .o_e           (o_e),
    .o_rs          (o_rs),
    .o_db          (o_db)
  );

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_hd44780_ctrl.sv
// Directed bench: a 4-bit 2x16 panel and an 8-bit 4x20 panel driven from one 250 kHz clock.
module tb_hd44780_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'h00;
  logic       refresh = 1'b0;
  logic       busy, done, e, rs;
  logic [3:0] db;

  logic       refresh8 = 1'b0;
  logic       busy8, done8, e8, rs8;
  logic [7:0] db8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hd44780_ctrl #(.CLK_HZ(250_000), .BUS_WIDTH(4), .ROWS(2), .COLS(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_refresh(refresh), .o_busy(busy), .o_done(done), .o_e(e), .o_rs(rs), .o_db(db)
  );

  hd44780_ctrl #(.CLK_HZ(250_000), .BUS_WIDTH(8), .ROWS(4), .COLS(20)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(1'b0), .i_wr_addr(7'd0), .i_wr_data(8'h00),
    .i_refresh(refresh8), .o_busy(busy8), .o_done(done8), .o_e(e8), .o_rs(rs8), .o_db(db8)
  );

  // Bus monitors: one entry {rs, db} per rising e, plus timing and stability bookkeeping.
  int         cyc = 0;
  logic [4:0] q4[$];
  logic [8:0] q8[$];
  logic       prev_e = 1'b0, prev_busy = 1'b0, prev_e8 = 1'b0;
  logic [4:0] prev_bus = 5'd0;
  int         last_pulse = 0, fall_cyc = 0, done_cnt = 0, done_bad = 0, stab_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (e && !prev_e) begin
      q4.push_back({rs, db});
      last_pulse = cyc;
    end
    if (!e && prev_e && ({rs, db} !== prev_bus)) stab_err++;
    if (done) done_cnt++;
    if (done && !(prev_busy && !busy)) done_bad++;
    if (prev_busy && !busy) fall_cyc = cyc;
    if (e8 && !prev_e8) q8.push_back({rs8, db8});
    prev_e    = e;
    prev_e8   = e8;
    prev_bus  = {rs, db};
    prev_busy = busy;
  end

  localparam logic [4:0] EXP_INIT4 [12] = '{5'h3, 5'h3, 5'h3, 5'h2, 5'h2, 5'h8,
                                            5'h0, 5'hC, 5'h0, 5'h6, 5'h0, 5'h1};
  localparam logic [8:0] EXP_INIT8 [7]  = '{9'h030, 9'h030, 9'h030, 9'h038,
                                            9'h00C, 9'h006, 9'h001};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_first_pulse(output int n);
    n = 0;
    while (!e && n < 30000) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || busy8) && n < bound) begin
      step(1);
      n++;
    end
    check("idle_reached", {30'd0, busy, busy8}, 32'd0);
  endtask

  function automatic logic [8:0] exp_refresh4(input int i);
    int a;
    if (i == 0)  return 9'h080;
    if (i == 17) return 9'h0C0;
    a = (i < 17) ? i - 1 : i - 2;
    if (a == 0)  return 9'h148;
    if (a == 17) return 9'h169;
    return 9'h120;
  endfunction

  initial begin
    int         n;
    int         d0;
    int         bad;
    logic [8:0] b;

    // Reset values
    step(3);
    check("rst_e", {31'd0, e}, 32'd0);
    check("rst_rs", {31'd0, rs}, 32'd0);
    check("rst_db", {28'd0, db}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd1);

    // Power-on wait, then the init sequences of both panels
    rst = 1'b0;
    wait_first_pulse(n);
    check("por_len_ok", {31'd0, (n >= 25000 && n <= 25005)}, 32'd1);
    check("first_pulse", {27'd0, rs, db}, 32'h3);
    wait_idle(5000);
    check("init4_count", q4.size(), 12);
    for (int i = 0; i < 12 && i < q4.size(); i++)
      check($sformatf("init4_%0d", i), {27'd0, q4[i]}, {27'd0, EXP_INIT4[i]});
    check("init4_busy_fall", fall_cyc - last_pulse, 413);
    check("init4_no_done", done_cnt, 0);
    check("init8_count", q8.size(), 7);
    for (int i = 0; i < 7 && i < q8.size(); i++)
      check($sformatf("init8_%0d", i), {23'd0, q8[i]}, {23'd0, EXP_INIT8[i]});

    // Refresh content with two host writes
    q4.delete();
    q8.delete();
    wr_en = 1'b1; wr_addr = 5'd0;  wr_data = 8'h48; step(1);
    wr_addr = 5'd17; wr_data = 8'h69; step(1);
    wr_en = 1'b0;
    refresh = 1'b1; refresh8 = 1'b1; step(1);
    refresh = 1'b0; refresh8 = 1'b0;
    check("ref_latency_busy", {31'd0, busy}, 32'd1);
    check("ref_latency_setup", {30'd0, e, rs}, 32'd0);
    check("ref_latency_db", {28'd0, db}, 32'h8);
    wait_idle(3000);
    step(2);
    check("ref_done_cnt", done_cnt, 1);
    check("ref4_count", q4.size(), 68);
    for (int i = 0; i < 34 && 2 * i + 1 < q4.size(); i++) begin
      b = {q4[2*i][4], q4[2*i][3:0], q4[2*i+1][3:0]};
      check($sformatf("ref4_byte_%0d", i), {23'd0, b}, {23'd0, exp_refresh4(i)});
    end
    check("ref8_count", q8.size(), 84);
    if (q8.size() == 84) begin
      check("ref8_row0", {23'd0, q8[0]},  32'h080);
      check("ref8_row1", {23'd0, q8[21]}, 32'h0C0);
      check("ref8_row2", {23'd0, q8[42]}, 32'h094);
      check("ref8_row3", {23'd0, q8[63]}, 32'h0D4);
      bad = 0;
      for (int i = 0; i < 84; i++)
        if ((i % 21) != 0 && q8[i] !== 9'h120) bad++;
      check("ref8_data", bad, 0);
    end

    // Three requests during an active refresh merge into one extra refresh
    d0 = done_cnt;
    refresh = 1'b1; step(1); refresh = 1'b0;
    step(50);
    for (int i = 0; i < 3; i++) begin
      refresh = 1'b1; step(1); refresh = 1'b0; step(20);
    end
    step(3000);
    check("queue_done_pulses", done_cnt - d0, 2);
    check("queue_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a refresh
    q4.delete();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h41; step(1); wr_en = 1'b0;
    refresh = 1'b1; step(1); refresh = 1'b0;
    n = 0;
    while (!rs && n < 200) begin
      step(1);
      n++;
    end
    check("midref_in_write_char", {31'd0, rs}, 32'd1);
    rst = 1'b1; step(1);
    check("midrst_e", {31'd0, e}, 32'd0);
    check("midrst_rs", {31'd0, rs}, 32'd0);
    check("midrst_db", {28'd0, db}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    wait_first_pulse(n);
    check("midrst_por_len_ok", {31'd0, (n >= 25000 && n <= 25005)}, 32'd1);
    wait_idle(5000);
    q4.delete();
    d0 = done_cnt;
    refresh = 1'b1; step(1); refresh = 1'b0;
    wait_idle(3000);
    step(2);
    check("midrst_ref_done", done_cnt - d0, 1);
    check("midrst_ref_count", q4.size(), 68);
    bad = 0;
    for (int i = 0; i < 34 && 2 * i + 1 < q4.size(); i++) begin
      b = {q4[2*i][4], q4[2*i][3:0], q4[2*i+1][3:0]};
      if (i != 0 && i != 17 && b !== 9'h120) bad++;
    end
    check("midrst_buffer_spaces", bad, 0);

    check("bus_hold_stable", stab_err, 0);
    check("done_only_at_busy_fall", done_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
